// File: rtl/fc_dense_stage.sv
// Fully-connected dense stage (LeNet5 F6): buffers one input frame, then runs one MAC per cycle per neuron.
// Define FC_DENSE_SATURATE_EN to saturate product truncation and accumulation instead of wrapping.
module fc_dense_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 15,
  parameter int IN_COUNT        = 120,
  parameter int OUT_COUNT       = 84,
  parameter int FRAC_BITS       = 0,
  parameter int ADDRESS_SIZE_WM = $clog2(IN_COUNT*OUT_COUNT),
  parameter int ADDRESS_SIZE_BM = $clog2(OUT_COUNT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        riscv_data,
  input  logic [ADDRESS_BITS-1:0]      riscv_address,
  input  logic                         wm_enable_write,
  input  logic                         bm_enable_write,
  input  logic                         relu_enable,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(OUT_COUNT)-1:0] out_index,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W    = $clog2(IN_COUNT);
  localparam int OIDX_W   = $clog2(OUT_COUNT);
  localparam int CYC_W    = $clog2(IN_COUNT+2);
  localparam int WM_DEPTH = IN_COUNT*OUT_COUNT;

  localparam logic [CYC_W-1:0]  LAST_MAC = CYC_W'(IN_COUNT);
  localparam logic [CYC_W-1:0]  EMIT_CYC = CYC_W'(IN_COUNT+1);
  localparam logic [IDX_W-1:0]  LAST_IN  = IDX_W'(IN_COUNT-1);
  localparam logic [OIDX_W-1:0] LAST_OUT = OIDX_W'(OUT_COUNT-1);

  localparam logic [0:0] FILL    = 1'b0;
  localparam logic [0:0] COMPUTE = 1'b1;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] w_mem [WM_DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [OUT_COUNT];
  logic [DATA_WIDTH-1:0] x_mem [IN_COUNT];

  logic [0:0]                 state_q, state_d;
  logic                       start_q, start_d;
  logic [IDX_W-1:0]           in_cnt_q, in_cnt_d;
  logic [CYC_W-1:0]           cyc_q, cyc_d;
  logic [OIDX_W-1:0]          neuron_q, neuron_d;
  logic [ADDRESS_SIZE_WM-1:0] w_ptr_q, w_ptr_d;
  logic [DATA_WIDTH-1:0]      acc_q, acc_d;
  logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
  logic [OIDX_W-1:0]          out_index_q, out_index_d;
  logic [DATA_WIDTH-1:0]      w_rd_q, b_rd_q, x_rd_q;

  logic [ADDRESS_SIZE_WM-1:0] wm_addr;
  logic [ADDRESS_SIZE_BM-1:0] bm_addr;
  logic [IDX_W-1:0]           x_rd_addr;
  logic                       emit;
  logic [DATA_WIDTH-1:0]      relu_result;
  logic                       unused_addr_bits;

  assign wm_addr          = riscv_address[ADDRESS_SIZE_WM-1:0];
  assign bm_addr          = riscv_address[ADDRESS_SIZE_BM-1:0];
  assign unused_addr_bits = ^riscv_address[ADDRESS_BITS-1:ADDRESS_SIZE_WM];
  assign x_rd_addr        = (cyc_q < LAST_MAC) ? cyc_q[IDX_W-1:0] : '0;

  function automatic logic [DATA_WIDTH-1:0] scaled_product(input logic [DATA_WIDTH-1:0] w,
                                                           input logic [DATA_WIDTH-1:0] x);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = ($signed(w) * $signed(x)) >>> FRAC_BITS;
`ifdef FC_DENSE_SATURATE_EN
    if (p[2*DATA_WIDTH-1:DATA_WIDTH-1] != '0 && p[2*DATA_WIDTH-1:DATA_WIDTH-1] != '1)
      scaled_product = p[2*DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
    else
      scaled_product = DATA_WIDTH'(p);
`else
    scaled_product = DATA_WIDTH'(p);
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] acc_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] s;
    s = a + b;
`ifdef FC_DENSE_SATURATE_EN
    // Overflow only when both operands share a sign that the sum lost.
    if (a[DATA_WIDTH-1] == b[DATA_WIDTH-1] && s[DATA_WIDTH-1] != a[DATA_WIDTH-1])
      s = a[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
    acc_add = s;
  endfunction

  // Memories are not reset; every read is registered, one cycle latency.
  always_ff @(posedge clk) begin
    if (state_q == FILL && wm_enable_write && int'(wm_addr) < WM_DEPTH)
      w_mem[wm_addr] <= riscv_data;
    if (state_q == FILL && bm_enable_write && int'(bm_addr) < OUT_COUNT)
      b_mem[bm_addr] <= riscv_data;
    if (state_q == FILL && in_valid)
      x_mem[in_cnt_q] <= in_data;
    w_rd_q <= w_mem[w_ptr_q];
    b_rd_q <= b_mem[neuron_q];
    x_rd_q <= x_mem[x_rd_addr];
  end

  assign emit        = (state_q == COMPUTE) && !start_q && (cyc_q == EMIT_CYC);
  assign relu_result = (relu_enable && acc_q[DATA_WIDTH-1]) ? '0 : acc_q;

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    in_cnt_d    = in_cnt_q;
    cyc_d       = cyc_q;
    neuron_d    = neuron_q;
    w_ptr_d     = w_ptr_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    if (state_q == FILL) begin
      if (in_valid) begin
        if (in_cnt_q == LAST_IN) begin
          in_cnt_d = '0;
          state_d  = COMPUTE;
          start_d  = 1'b1;
          cyc_d    = '0;
          neuron_d = '0;
          w_ptr_d  = '0;
          acc_d    = '0;
        end else begin
          in_cnt_d = in_cnt_q + 1'b1;
        end
      end
    // The settle cycle after the last input aligns neuron 0 to IN_COUNT+2 edges after acceptance.
    end else if (!start_q) begin
      if (cyc_q < LAST_MAC)
        w_ptr_d = w_ptr_q + 1'b1;
      if (cyc_q == '0)
        acc_d = '0;
      else if (cyc_q <= LAST_MAC)
        acc_d = acc_add((cyc_q == CYC_W'(1)) ? b_rd_q : acc_q, scaled_product(w_rd_q, x_rd_q));
      if (emit) begin
        out_data_d  = relu_result;
        out_index_d = neuron_q;
        cyc_d       = '0;
        if (neuron_q == LAST_OUT) begin
          state_d  = FILL;
          neuron_d = '0;
          w_ptr_d  = '0;
        end else begin
          neuron_d = neuron_q + 1'b1;
        end
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      start_q     <= 1'b0;
      in_cnt_q    <= '0;
      cyc_q       <= '0;
      neuron_q    <= '0;
      w_ptr_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      in_cnt_q    <= in_cnt_d;
      cyc_q       <= cyc_d;
      neuron_q    <= neuron_d;
      w_ptr_q     <= w_ptr_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  // The EMIT cycle shows the live result; the registered copy holds it until the next EMIT.
  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q == COMPUTE);
  assign out_valid = emit;
  assign out_data  = emit ? relu_result : out_data_q;
  assign out_index = emit ? neuron_q : out_index_q;
  assign done      = emit && (neuron_q == LAST_OUT);

endmodule

// File: tb/tb_fc_dense_stage.sv
// Directed self-checking bench for fc_dense_stage with a 4-input, 3-neuron configuration.
module tb_fc_dense_stage;
  localparam int DW = 32;
  localparam int AB = 15;
  localparam int IC = 4;
  localparam int OC = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] riscv_data;
  logic [AB-1:0] riscv_address;
  logic          wm_enable_write;
  logic          bm_enable_write;
  logic          relu_enable;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_index;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rx_data  [3];
  int          rx_index [3];
  logic        rx_done  [3];
  int          rx_off   [3];
  int          rx_got;
  int          ready_leak;

  always #5 clk = ~clk;

  fc_dense_stage #(
    .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .IN_COUNT(IC), .OUT_COUNT(OC), .FRAC_BITS(0)
  ) dut (
    .clk(clk), .reset(reset), .riscv_data(riscv_data), .riscv_address(riscv_address),
    .wm_enable_write(wm_enable_write), .bm_enable_write(bm_enable_write),
    .relu_enable(relu_enable), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write_w(input int idx, input logic [31:0] v);
    wm_enable_write = 1'b1;
    riscv_address   = AB'(idx);
    riscv_data      = v;
    @(negedge clk);
    wm_enable_write = 1'b0;
  endtask

  task automatic write_b(input int idx, input logic [31:0] v);
    bm_enable_write = 1'b1;
    riscv_address   = AB'(idx);
    riscv_data      = v;
    @(negedge clk);
    bm_enable_write = 1'b0;
  endtask

  task automatic set_row(input int j, input logic [31:0] v);
    for (int i = 0; i < IC; i++) write_w(j*IC + i, v);
  endtask

  // Returns at the negedge just after the edge that accepted the last word.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d);
    logic [31:0] f [4];
    f = '{a, b, c, d};
    for (int i = 0; i < IC; i++) begin
      in_valid = 1'b1;
      in_data  = f[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Offset 0 is the cycle starting at the accepting edge; optionally writes bias[2] mid-compute.
  task automatic collect(input int n, input bit busy_write);
    int got;
    got = 0;
    ready_leak = 0;
    for (int k = 0; k < 3; k++) begin
      rx_data[k] = 'x; rx_index[k] = -1; rx_done[k] = 1'b0; rx_off[k] = -1;
    end
    for (int off = 0; off <= 40 && got < n; off++) begin
      if (off >= 1 && in_ready !== 1'b0) ready_leak++;
      if (out_valid === 1'b1) begin
        rx_data[got]  = out_data;
        rx_index[got] = int'(out_index);
        rx_done[got]  = done;
        rx_off[got]   = off;
        got++;
      end
      if (busy_write && off == 3) begin
        bm_enable_write = 1'b1;
        riscv_address   = AB'(2);
        riscv_data      = 32'd999;
      end else begin
        bm_enable_write = 1'b0;
      end
      @(negedge clk);
    end
    bm_enable_write = 1'b0;
    rx_got = got;
  endtask

  task automatic check_frame(input string nm, input logic [31:0] e0,
                             input logic [31:0] e1, input logic [31:0] e2);
    check_output({nm, " count"}, rx_got, 3);
    check_output({nm, " data0"}, rx_data[0], e0);
    check_output({nm, " data1"}, rx_data[1], e1);
    check_output({nm, " data2"}, rx_data[2], e2);
    for (int k = 0; k < 3; k++) begin
      check_output({nm, " index"}, rx_index[k], k);
      check_output({nm, " latency"}, rx_off[k], 6*(k+1));
    end
    check_output({nm, " done"}, {29'd0, rx_done[2], rx_done[1], rx_done[0]}, 32'b100);
    check_output({nm, " in_ready_low"}, ready_leak, 0);
    check_output({nm, " in_ready_after"}, {31'd0, in_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stray;
    reset = 1'b1;
    riscv_data = '0; riscv_address = '0; wm_enable_write = 1'b0; bm_enable_write = 1'b0;
    relu_enable = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check_output("rst out_valid", {31'd0, out_valid}, 0);
    check_output("rst done", {31'd0, done}, 0);
    check_output("rst busy", {31'd0, busy}, 0);
    check_output("rst out_data", out_data, 0);
    check_output("rst out_index", {30'd0, out_index}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_output("rst in_ready", {31'd0, in_ready}, 1);

    for (int j = 0; j < OC; j++) set_row(j, 32'd1);
    write_b(0, 32'd0);
    write_b(1, 32'd10);
    write_b(2, -32'sd5);

    $display("[TB] basic frame");
    apply_stimulus(1, 2, 3, 4);
    collect(3, 1'b0);
    check_frame("basic", 10, 20, 5);

    $display("[TB] back-to-back frame");
    apply_stimulus(1, 2, 3, 4);
    collect(3, 1'b0);
    check_frame("b2b", 10, 20, 5);

    $display("[TB] bias write while busy, then in fill");
    apply_stimulus(1, 2, 3, 4);
    collect(3, 1'b1);
    check_frame("busywr", 10, 20, 5);
    write_b(2, 32'd999);
    apply_stimulus(1, 2, 3, 4);
    collect(3, 1'b0);
    check_frame("fillwr", 10, 20, 1009);
    write_b(2, -32'sd5);

    $display("[TB] relu");
    set_row(0, 32'd0);
    write_b(0, -32'sd100);
    relu_enable = 1'b0;
    apply_stimulus(1, 2, 3, 4);
    collect(3, 1'b0);
    check_frame("relu_off", 32'hFFFFFF9C, 20, 5);
    relu_enable = 1'b1;
    apply_stimulus(1, 2, 3, 4);
    collect(3, 1'b0);
    check_frame("relu_on", 0, 20, 5);
    relu_enable = 1'b0;

    $display("[TB] overflow");
    set_row(0, 32'h40000000);
    write_b(0, 32'd0);
    apply_stimulus(4, 0, 0, 0);
    collect(3, 1'b0);
`ifdef FC_DENSE_SATURATE_EN
    check_frame("ovf", 32'h7FFFFFFF, 14, 32'hFFFFFFFF);
`else
    check_frame("ovf", 32'h00000000, 14, 32'hFFFFFFFF);
`endif

    $display("[TB] reset mid-compute");
    set_row(0, 32'd1);
    apply_stimulus(1, 2, 3, 4);
    collect(1, 1'b0);
    check_output("midrst first", rx_data[0], 10);
    reset = 1'b1;
    #1;
    check_output("midrst out_valid", {31'd0, out_valid}, 0);
    check_output("midrst done", {31'd0, done}, 0);
    check_output("midrst in_ready", {31'd0, in_ready}, 1);
    check_output("midrst busy", {31'd0, busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid !== 1'b0) stray++;
      @(negedge clk);
    end
    check_output("midrst no_results", stray, 0);
    check_output("midrst in_ready_idle", {31'd0, in_ready}, 1);
    apply_stimulus(1, 2, 3, 4);
    collect(3, 1'b0);
    check_frame("after_rst", 10, 20, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
